// File: rtl/sipo_pkg.sv
// sipo_pkg: default word width and state encoding shared by the deserializer files.
package sipo_pkg;
    localparam int WIDTH_DEF = 4;
    typedef enum logic {SHIFT = 1'b0, PARITY = 1'b1} state_t;
endpackage

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial input, parallel word handshake and status flags of sipo_deser.
interface sipo_deser_if import sipo_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic si;
    logic si_valid;
    logic [WIDTH-1:0] word_q;
    logic word_valid;
    logic word_ready;
    logic overflow;
    logic parity_err;
    modport master (output si, si_valid, word_ready, input word_q, word_valid, overflow, parity_err);
    modport slave (input si, si_valid, word_ready, output word_q, word_valid, overflow, parity_err);
endinterface

// File: rtl/sipo_shift.sv
// sipo_shift: MSB-first shift register with shift enable and synchronous clear.
module sipo_shift import sipo_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (clr) q <= '0;
        else if (en) q <= {q[WIDTH-2:0], d};
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with one-word output buffer and overflow flag.
// Define SIPO_DESER_PARITY_EN to append an even-parity bit to every word.
module sipo_deser import sipo_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
    input logic       clk,
    input logic       rst,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] sh_q, word_d;
    logic last, done, perr, xfer;
    sipo_shift #(.WIDTH(WIDTH)) u_shift (
        .clk(clk),
        .clr(rst),
        .en(bus.si_valid && state == SHIFT),
        .d(bus.si),
        .q(sh_q)
    );
    always_comb begin
        last = bus.si_valid && state == SHIFT && cnt == CW'(WIDTH - 1);
        xfer = bus.word_valid && bus.word_ready;
`ifdef SIPO_DESER_PARITY_EN
        // data bits stay in the shifter while the parity bit is checked
        state_d = last ? PARITY : (bus.si_valid && state == PARITY) ? SHIFT : state;
        cnt_d = (bus.si_valid && state == PARITY) ? '0 : (bus.si_valid && !last) ? cnt + 1'b1 : cnt;
        word_d = sh_q;
        done = bus.si_valid && state == PARITY && (^sh_q == bus.si);
        perr = bus.si_valid && state == PARITY && (^sh_q != bus.si);
`else
        state_d = SHIFT;
        cnt_d = bus.si_valid ? (last ? '0 : cnt + 1'b1) : cnt;
        word_d = {sh_q[WIDTH-2:0], bus.si};
        done = last;
        perr = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHIFT;
            cnt <= '0;
            bus.word_q <= '0;
            bus.word_valid <= 1'b0;
            bus.overflow <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            bus.parity_err <= perr;
            // a completed word only fits if the buffer is empty or draining this edge
            if (done && (!bus.word_valid || xfer)) begin
                bus.word_q <= word_d;
                bus.word_valid <= 1'b1;
            end else begin
                if (xfer) bus.word_valid <= 1'b0;
                if (done) bus.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed and randomized checks of sipo_deser against a bit-queue reference model.
module tb_sipo_deser;
    localparam int W = 4;
`ifdef SIPO_DESER_PARITY_EN
    localparam bit P = 1'b1;
`else
    localparam bit P = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int passed = 0;
    bit cur[$];
    logic [W-1:0] exp_q;
    logic exp_v, exp_ov, exp_pe;

    sipo_deser_if #(.WIDTH(W)) bus ();
    sipo_deser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference: collect accepted bits in a queue; a full queue is one word (plus parity bit).
    task automatic model(input logic r, input logic s, input logic sv, input logic wr);
        logic old_v, ok;
        logic [W-1:0] w;
        if (r) begin
            cur.delete();
            exp_q = '0;
            exp_v = 1'b0;
            exp_ov = 1'b0;
            exp_pe = 1'b0;
            return;
        end
        old_v = exp_v;
        exp_pe = 1'b0;
        if (old_v && wr) exp_v = 1'b0;
        if (sv) begin
            cur.push_back(s);
            if (cur.size() == W + int'(P)) begin
                w = '0;
                for (int i = 0; i < W; i++) w = {w[W-2:0], cur[i]};
                ok = !P || ((^w) == cur[W]);
                cur.delete();
                if (!ok) exp_pe = 1'b1;
                else if (!old_v || wr) begin
                    exp_q = w;
                    exp_v = 1'b1;
                end else exp_ov = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic sv, input logic wr);
        rst = r;
        bus.si = s;
        bus.si_valid = sv;
        bus.word_ready = wr;
        @(posedge clk);
        model(r, s, sv, wr);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic wr, input logic last_wr, input int gap);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, w[i], 1'b1, (i == 0 && !P) ? last_wr : wr);
            if (i > 0 || P) repeat (gap) step(1'b0, 1'b0, 1'b0, wr);
        end
        if (P) step(1'b0, ^w, 1'b1, last_wr);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (bus.word_q !== 4'b0000) $display("FAIL reset_q got %b want 0000", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.word_valid); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow); else passed++;
        total++; if (bus.parity_err !== 1'b0) $display("FAIL reset_perr got %b want 0", bus.parity_err); else passed++;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_word(4'b1010, 1'b1, 1'b1, 0);
        total++; if (bus.word_q !== 4'b1010) $display("FAIL basic_q got %b want 1010", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.word_valid); else passed++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.word_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", bus.word_valid); else passed++;
    endtask

    task automatic test_gaps_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        total++; if (bus.word_valid !== 1'b0) $display("FAIL gaps_rst_valid got %b want 0", bus.word_valid); else passed++;
        send_word(4'b0110, 1'b0, 1'b0, 2);
        total++; if (bus.word_q !== 4'b0110) $display("FAIL gaps_q got %b want 0110", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b1) $display("FAIL gaps_valid got %b want 1", bus.word_valid); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL gaps_ovf got %b want 0", bus.overflow); else passed++;
    endtask

    task automatic test_backpressure();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1111, 1'b0, 1'b0, 0);
        total++; if (bus.overflow !== 1'b0) $display("FAIL bp_ovf_first got %b want 0", bus.overflow); else passed++;
        send_word(4'b0011, 1'b0, 1'b0, 0);
        total++; if (bus.word_q !== 4'b1111) $display("FAIL bp_q got %b want 1111", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.word_valid); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("FAIL bp_ovf got %b want 1", bus.overflow); else passed++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.overflow !== 1'b1) $display("FAIL bp_ovf_sticky got %b want 1", bus.overflow); else passed++;
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1010, 1'b0, 1'b0, 0);
        send_word(4'b0101, 1'b0, 1'b1, 0);
        total++; if (bus.word_q !== 4'b0101) $display("FAIL sim_q got %b want 0101", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b1) $display("FAIL sim_valid got %b want 1", bus.word_valid); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL sim_ovf got %b want 0", bus.overflow); else passed++;
    endtask

`ifdef SIPO_DESER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] bad;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1001, 1'b0, 1'b0, 0);
        total++; if (bus.word_q !== 4'b1001) $display("FAIL par_q got %b want 1001", bus.word_q); else passed++;
        total++; if (bus.word_valid !== 1'b1) $display("FAIL par_valid got %b want 1", bus.word_valid); else passed++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        bad = 4'b1100;
        for (int i = W - 1; i >= 0; i--) step(1'b0, bad[i], 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (bus.parity_err !== 1'b1) $display("FAIL par_err got %b want 1", bus.parity_err); else passed++;
        total++; if (bus.word_valid !== 1'b0) $display("FAIL par_err_valid got %b want 0", bus.word_valid); else passed++;
        total++; if (bus.word_q !== 4'b1001) $display("FAIL par_err_q got %b want 1001", bus.word_q); else passed++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.parity_err !== 1'b0) $display("FAIL par_err_pulse got %b want 0", bus.parity_err); else passed++;
    endtask
`endif

    task automatic test_random();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            total++; if (bus.word_q !== exp_q) $display("FAIL rnd_q cycle %0d got %b want %b", n, bus.word_q, exp_q); else passed++;
            total++; if (bus.word_valid !== exp_v) $display("FAIL rnd_valid cycle %0d got %b want %b", n, bus.word_valid, exp_v); else passed++;
            total++; if (bus.overflow !== exp_ov) $display("FAIL rnd_ovf cycle %0d got %b want %b", n, bus.overflow, exp_ov); else passed++;
            total++; if (bus.parity_err !== exp_pe) $display("FAIL rnd_perr cycle %0d got %b want %b", n, bus.parity_err, exp_pe); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.si = 1'b0;
        bus.si_valid = 1'b0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps_reset();
        test_backpressure();
        test_simultaneous();
`ifdef SIPO_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per assembled word (legal 2..32).
REQ-002 Port: clk  input  1  single clock for all state; all sequential updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: si  input  1  serial data bit.
REQ-005 Port: si_valid  input  1  si carries a valid bit this cycle; no backpressure toward the serial side.
REQ-006 Port: word_q  output  WIDTH  assembled parallel word, suitable to drive a downstream parallel-in parallel-out register D input.
REQ-007 Port: word_valid  output  1  word_q holds an undelivered word.
REQ-008 Port: word_ready  input  1  downstream accepts word_q this cycle.
REQ-009 Port: overflow  output  1  sticky flag, a completed word was dropped.
REQ-010 Port: parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).

Function
REQ-011 A bit is accepted on each rising edge where si_valid=1; idle cycles (si_valid=0) leave all assembly state unchanged.
REQ-012 Bits are MSB-first: the first accepted bit of a word lands in word_q[WIDTH-1], the last in word_q[0].
REQ-013 The bit counter runs 0..WIDTH-1 and wraps to 0 on the edge that accepts the last data bit (or parity bit when enabled).
REQ-014 States: SHIFT (collecting data bits) and PARITY (one extra bit, only when the macro is defined); SHIFT->PARITY on last data bit, PARITY->SHIFT on parity bit.
REQ-015 On the edge completing a word, the word is loaded into word_q and word_valid=1 from the next cycle on (1-cycle latency after the last bit).
REQ-016 Transfer occurs on an edge where word_valid=1 and word_ready=1; word_valid then clears unless a new word completes on that same edge.
REQ-017 Simultaneous completion and transfer: the new word loads, word_valid stays 1, overflow unchanged.
REQ-018 Completion while word_valid=1 and word_ready=0: the new word is dropped, word_q keeps the old word, overflow sets to 1 and stays 1 until reset.
REQ-019 word_q is stable while word_valid=1 and no transfer occurs.

Reset
REQ-020 While rst=1 at an edge: word_q=0, word_valid=0, overflow=0, parity_err=0, bit counter=0, state=SHIFT.
REQ-021 Reset mid-word discards all partially accepted bits; the next accepted bit after reset is the MSB of a new word.
REQ-022 si_valid is ignored on any edge where rst=1.

Configuration
REQ-023 Macro SIPO_DESER_PARITY_EN, when defined, enables the PARITY state: each word is followed by one even-parity bit covering the WIDTH data bits.
REQ-024 With the macro: a matching parity bit completes the word per REQ-015..018; a mismatch discards the word, leaves word_q/word_valid/overflow unchanged, and pulses parity_err for exactly one cycle.
REQ-025 Without the macro: no PARITY state, words complete on the last data bit, parity_err is tied to 0; port list unchanged.

Structure
REQ-026 Shared package sipo_pkg holds the default WIDTH constant and the state encoding (SHIFT, PARITY).
REQ-027 One sub-module, sipo_shift: WIDTH-bit MSB-first shift register with shift enable and synchronous clear; sipo_deser holds the counter, FSM, output register and flags.

Verification
REQ-028 Reset: rst=1 for 2 cycles -> word_q=0000, word_valid=0, overflow=0, parity_err=0.
REQ-029 Basic: si=1,0,1,0 on 4 consecutive valid cycles, word_ready=1 -> word_q=1010, word_valid=1 for exactly one cycle, starting the cycle after the 4th bit.
REQ-030 Gaps plus reset mid-word: bits 1,1 then rst, then bits 0,1,1,0 with idle cycles between bits -> word_q=0110, no residue of the first bits.
REQ-031 Backpressure: word_ready=0, send 1111 then 0011 -> word_q stays 1111, word_valid=1, overflow=1 after 8th bit.
REQ-032 Simultaneous: 1010 pending, word_ready=1 on the edge accepting the last bit of 0101 -> word_q=0101, word_valid stays 1, overflow=0.
REQ-033 Parity (macro defined): 1001 + parity 0 -> word_q=1001 valid; 1100 + parity 1 -> parity_err one-cycle pulse, word_valid not asserted.
